// File: rtl/litedram_arb_pkg.sv
// litedram_arb_pkg: arbiter state encodings and default widths shared by the arbiter files.
package litedram_arb_pkg;
    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_CMD   = 2'd1,
        ARB_WDATA = 2'd2,
        ARB_RDATA = 2'd3
    } arb_state_e;
    localparam int ARB_NUM_PORTS = 2;
    localparam int ARB_ADDR_W    = 24;
    localparam int ARB_DATA_W    = 128;
endpackage

// File: rtl/litedram_port_arbiter_rr_arbiter.sv
// rr_arbiter: combinational request picker, round-robin from a pointer or fixed lowest-index priority.
//   req_i  : request vector, one bit per master
//   ptr_i  : round-robin start index (ignored in fixed-priority builds)
//   gnt_o  : index of the selected requester (0 when nothing requests)
//   any_o  : at least one request is present
//   Optional macro LITEDRAM_ARB_FIXED_PRIO_EN selects fixed priority.
module rr_arbiter
    import litedram_arb_pkg::*;
#(
    parameter int N  = ARB_NUM_PORTS,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [PW-1:0] gnt_o,
    output logic          any_o
);
    assign any_o = |req_i;
`ifdef LITEDRAM_ARB_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr_i;
    // Descending scan: the lowest requesting index is written last and wins.
    always_comb begin
        gnt_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) gnt_o = PW'(i);
        end
    end
`else
    // Descending offset scan: the requester closest to the pointer is written last and wins.
    always_comb begin
        gnt_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[(int'(ptr_i) + i) % N]) gnt_o = PW'((int'(ptr_i) + i) % N);
        end
    end
`endif
endmodule

// File: rtl/litedram_port_arbiter.sv
// litedram_port_arbiter: merges NUM_PORTS LiteDRAM native masters onto one user port, one transaction in flight.
//   clk_i, rst_ni              : clock, asynchronous active-low reset
//   m_cmd_*                    : per-master command channels (valid/ready/addr/we)
//   m_wdata_*                  : per-master write-data channels (valid/ready/data/byte enables)
//   m_rdata_*                  : per-master read-data valid/ready, read data broadcast to all masters
//   litedram_cmd/wdata/rdata_* : the single downstream LiteDRAM native port
//   Optional macro LITEDRAM_ARB_FIXED_PRIO_EN: fixed lowest-index priority, no pointer register.
module litedram_port_arbiter
    import litedram_arb_pkg::*;
#(
    parameter int NUM_PORTS = ARB_NUM_PORTS,
    parameter int ADDR_W    = ARB_ADDR_W,
    parameter int DATA_W    = ARB_DATA_W
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_PORTS-1:0]          m_cmd_valid_i,
    output logic [NUM_PORTS-1:0]          m_cmd_ready_o,
    input  logic [NUM_PORTS*ADDR_W-1:0]   m_cmd_addr_i,
    input  logic [NUM_PORTS-1:0]          m_cmd_we_i,
    input  logic [NUM_PORTS-1:0]          m_wdata_valid_i,
    output logic [NUM_PORTS-1:0]          m_wdata_ready_o,
    input  logic [NUM_PORTS*DATA_W-1:0]   m_wdata_data_i,
    input  logic [NUM_PORTS*DATA_W/8-1:0] m_wdata_we_i,
    output logic [NUM_PORTS-1:0]          m_rdata_valid_o,
    input  logic [NUM_PORTS-1:0]          m_rdata_ready_i,
    output logic [DATA_W-1:0]             m_rdata_data_o,
    output logic                          litedram_cmd_valid_o,
    input  logic                          litedram_cmd_ready_i,
    output logic [ADDR_W-1:0]             litedram_cmd_addr_o,
    output logic                          litedram_cmd_we_o,
    output logic                          litedram_wdata_valid_o,
    input  logic                          litedram_wdata_ready_i,
    output logic [DATA_W-1:0]             litedram_wdata_data_o,
    output logic [DATA_W/8-1:0]           litedram_wdata_we_o,
    input  logic                          litedram_rdata_valid_i,
    output logic                          litedram_rdata_ready_o,
    input  logic [DATA_W-1:0]             litedram_rdata_data_i
);
    localparam int PW = $clog2(NUM_PORTS);
    localparam int BW = DATA_W / 8;

    arb_state_e    state_q, state_d;
    logic [PW-1:0] grant_q, grant_d, ptr, arb_idx;
    logic          arb_any;

`ifdef LITEDRAM_ARB_FIXED_PRIO_EN
    assign ptr = '0;
`else
    logic [PW-1:0] ptr_q, ptr_d;
    assign ptr = ptr_q;
`endif

    rr_arbiter #(.N(NUM_PORTS), .PW(PW)) u_arb (
        .req_i (m_cmd_valid_i),
        .ptr_i (ptr),
        .gnt_o (arb_idx),
        .any_o (arb_any)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
`ifndef LITEDRAM_ARB_FIXED_PRIO_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
`ifndef LITEDRAM_ARB_FIXED_PRIO_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
`ifndef LITEDRAM_ARB_FIXED_PRIO_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (arb_any) begin
                    grant_d = arb_idx;
                    state_d = ARB_CMD;
                end
            end
            ARB_CMD: begin
                if (litedram_cmd_valid_o && litedram_cmd_ready_i) begin
`ifndef LITEDRAM_ARB_FIXED_PRIO_EN
                    ptr_d = (grant_q == PW'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;
`endif
                    state_d = litedram_cmd_we_o ? ARB_WDATA : ARB_RDATA;
                end
            end
            ARB_WDATA: state_d = (litedram_wdata_valid_o && litedram_wdata_ready_i) ? ARB_IDLE : ARB_WDATA;
            default:   state_d = (litedram_rdata_valid_i && litedram_rdata_ready_o) ? ARB_IDLE : ARB_RDATA;
        endcase
    end

    // Every per-master and downstream strobe is gated by the phase so idle outputs read as zero.
    always_comb begin
        litedram_cmd_valid_o   = (state_q == ARB_CMD) & m_cmd_valid_i[grant_q];
        litedram_cmd_addr_o    = (state_q == ARB_CMD) ? m_cmd_addr_i[grant_q*ADDR_W +: ADDR_W] : '0;
        litedram_cmd_we_o      = (state_q == ARB_CMD) & m_cmd_we_i[grant_q];
        m_cmd_ready_o          = (state_q == ARB_CMD) ? NUM_PORTS'(litedram_cmd_ready_i) << grant_q : '0;
        litedram_wdata_valid_o = (state_q == ARB_WDATA) & m_wdata_valid_i[grant_q];
        litedram_wdata_data_o  = (state_q == ARB_WDATA) ? m_wdata_data_i[grant_q*DATA_W +: DATA_W] : '0;
        litedram_wdata_we_o    = (state_q == ARB_WDATA) ? m_wdata_we_i[grant_q*BW +: BW] : '0;
        m_wdata_ready_o        = (state_q == ARB_WDATA) ? NUM_PORTS'(litedram_wdata_ready_i) << grant_q : '0;
        m_rdata_valid_o        = (state_q == ARB_RDATA) ? NUM_PORTS'(litedram_rdata_valid_i) << grant_q : '0;
        litedram_rdata_ready_o = (state_q == ARB_RDATA) & m_rdata_ready_i[grant_q];
        m_rdata_data_o         = litedram_rdata_data_i;
    end
endmodule

// File: tb/tb_litedram_port_arbiter.sv
// tb_litedram_port_arbiter: directed scoreboard bench for the two-port LiteDRAM arbiter.
module tb_litedram_port_arbiter;
    localparam int NP = 2;
    localparam int AW = 24;
    localparam int DW = 128;
    localparam int BW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NP-1:0]    m_cmd_valid = '0, m_cmd_we = '0, m_wdata_valid = '0, m_rdata_ready = '0;
    logic [NP-1:0]    m_cmd_ready, m_wdata_ready, m_rdata_valid;
    logic [NP*AW-1:0] m_cmd_addr = '0;
    logic [NP*DW-1:0] m_wdata = '0;
    logic [NP*BW-1:0] m_wbe = '0;
    logic [DW-1:0]    m_rdata;
    logic             l_cmd_valid, l_cmd_we, l_wvalid, l_rready;
    logic             l_cmd_ready = 1'b1, l_wready = 1'b1;
    logic [AW-1:0]    l_cmd_addr;
    logic [DW-1:0]    l_wdata, l_rdata;
    logic [BW-1:0]    l_wbe;
    logic             l_rvalid;
    logic             lrv = 1'b0, rd_hold = 1'b0, rd_force = 1'b0;
    logic [AW-1:0]    raddr = '0;

    always #5 clk = ~clk;

    litedram_port_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .m_cmd_valid_i(m_cmd_valid), .m_cmd_ready_o(m_cmd_ready), .m_cmd_addr_i(m_cmd_addr), .m_cmd_we_i(m_cmd_we),
        .m_wdata_valid_i(m_wdata_valid), .m_wdata_ready_o(m_wdata_ready), .m_wdata_data_i(m_wdata), .m_wdata_we_i(m_wbe),
        .m_rdata_valid_o(m_rdata_valid), .m_rdata_ready_i(m_rdata_ready), .m_rdata_data_o(m_rdata),
        .litedram_cmd_valid_o(l_cmd_valid), .litedram_cmd_ready_i(l_cmd_ready), .litedram_cmd_addr_o(l_cmd_addr),
        .litedram_cmd_we_o(l_cmd_we), .litedram_wdata_valid_o(l_wvalid), .litedram_wdata_ready_i(l_wready),
        .litedram_wdata_data_o(l_wdata), .litedram_wdata_we_o(l_wbe), .litedram_rdata_valid_i(l_rvalid),
        .litedram_rdata_ready_o(l_rready), .litedram_rdata_data_i(l_rdata)
    );

    // LiteDRAM side: answers each read one cycle after its command with a word tagged by the address.
    assign l_rvalid = lrv | rd_force;
    assign l_rdata  = {32'hDEADBEEF, 72'h0, raddr};
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) lrv <= 1'b0;
        else begin
            if (lrv && l_rready) lrv <= 1'b0;
            if (l_cmd_valid && l_cmd_ready && !l_cmd_we) begin
                lrv   <= !rd_hold;
                raddr <= l_cmd_addr;
            end
        end
    end

    typedef struct { int port; logic [AW-1:0] addr; logic we; } cmd_t;
    typedef struct { int port; logic [DW-1:0] data; logic [BW-1:0] be; } dat_t;
    cmd_t cq[$];
    dat_t wq[$];
    dat_t rq[$];
    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step;
        @(negedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rdw(input logic [AW-1:0] a);
        return {32'hDEADBEEF, 72'h0, a};
    endfunction

    task automatic expect_txn(input int p, input logic [AW-1:0] a, input logic we,
                              input logic [DW-1:0] d, input logic [BW-1:0] be);
        cq.push_back('{p, a, we});
        if (we) wq.push_back('{p, d, be});
        else    rq.push_back('{p, d, '0});
    endtask

    // One master transaction; caller starts it just after a falling edge.
    task automatic master(input int p, input logic [AW-1:0] a, input logic we,
                          input logic [DW-1:0] d, input logic [BW-1:0] be);
        int n;
        m_cmd_valid[p] = 1'b1;
        m_cmd_addr[p*AW +: AW] = a;
        m_cmd_we[p] = we;
        m_wdata_valid[p] = we;
        m_wdata[p*DW +: DW] = d;
        m_wbe[p*BW +: BW] = be;
        m_rdata_ready[p] = !we;
        n = 0;
        while (!m_cmd_ready[p] && n < 64) begin step(); n++; end
        if (n == 64) chk("cmd_timeout", 1'b0, 1'b1);
        step();
        m_cmd_valid[p] = 1'b0;
        n = 0;
        while (!(we ? m_wdata_ready[p] : m_rdata_valid[p]) && n < 64) begin step(); n++; end
        if (n == 64) chk("data_timeout", 1'b0, 1'b1);
        step();
        m_wdata_valid[p] = 1'b0;
        m_rdata_ready[p] = 1'b0;
    endtask

    // Scoreboard monitor: compares every handshake against the next queued expectation.
    cmd_t ce;
    dat_t de;
    always @(negedge clk) begin
        if (rst_n) begin
            if (l_cmd_valid && l_cmd_ready) begin
                if (cq.size() == 0) chk("cmd_unexpected", 1'b1, 1'b0);
                else begin
                    ce = cq.pop_front();
                    chk("cmd_addr", l_cmd_addr, ce.addr);
                    chk("cmd_we", l_cmd_we, ce.we);
                    chk("cmd_ready_vec", m_cmd_ready, NP'(1) << ce.port);
                end
            end
            if (l_wvalid && l_wready) begin
                if (wq.size() == 0) chk("wdata_unexpected", 1'b1, 1'b0);
                else begin
                    de = wq.pop_front();
                    chk("wdata_data", l_wdata, de.data);
                    chk("wdata_be", l_wbe, de.be);
                    chk("wdata_ready_vec", m_wdata_ready, NP'(1) << de.port);
                end
            end
            if (m_rdata_valid != '0 && l_rready) begin
                if (rq.size() == 0) chk("rdata_unexpected", 1'b1, 1'b0);
                else begin
                    de = rq.pop_front();
                    chk("rdata_valid_vec", m_rdata_valid, NP'(1) << de.port);
                    chk("rdata_data", m_rdata, de.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        m_cmd_valid = 2'b11;
        m_cmd_addr = '1;
        m_cmd_we = 2'b11;
        step();
        chk("rst_cmd_valid", l_cmd_valid, 1'b0);
        chk("rst_cmd_addr", l_cmd_addr, '0);
        chk("rst_cmd_we", l_cmd_we, 1'b0);
        chk("rst_cmd_ready", m_cmd_ready, '0);
        chk("rst_wvalid", l_wvalid, 1'b0);
        chk("rst_rdata_valid", m_rdata_valid, '0);
        chk("rst_rready", l_rready, 1'b0);
        m_cmd_valid = '0;
        m_cmd_addr = '0;
        m_cmd_we = '0;
        step();
        rst_n = 1'b1;
        step();

        expect_txn(0, 24'h000123, 1'b0, 128'hDEADBEEF_000000000000000000_000123, '0);
        fork
            master(0, 24'h000123, 1'b0, '0, '0);
            begin step(); chk("cmd_latency", l_cmd_valid, 1'b1); end
        join

        expect_txn(1, 24'h000456, 1'b1, 128'h00112233_44556677_8899AABB_CCDDCAFE, 16'h000F);
        master(1, 24'h000456, 1'b1, 128'h00112233_44556677_8899AABB_CCDDCAFE, 16'h000F);

        expect_txn(0, 24'h000010, 1'b0, rdw(24'h000010), '0);
        expect_txn(1, 24'h000020, 1'b0, rdw(24'h000020), '0);
        fork
            master(0, 24'h000010, 1'b0, '0, '0);
            master(1, 24'h000020, 1'b0, '0, '0);
        join
        expect_txn(0, 24'h000011, 1'b1, 128'h11111111_11111111_11111111_11111111, 16'hFFFF);
        expect_txn(1, 24'h000021, 1'b1, 128'h22222222_22222222_22222222_22222222, 16'hF0F0);
        fork
            master(0, 24'h000011, 1'b1, 128'h11111111_11111111_11111111_11111111, 16'hFFFF);
            master(1, 24'h000021, 1'b1, 128'h22222222_22222222_22222222_22222222, 16'hF0F0);
        join

        l_cmd_ready = 1'b0;
        expect_txn(0, 24'h0ABCDE, 1'b1, 128'h0, 16'h8001);
        fork
            master(0, 24'h0ABCDE, 1'b1, 128'h0, 16'h8001);
            begin
                step();
                repeat (5) begin
                    step();
                    chk("stall_valid", l_cmd_valid, 1'b1);
                    chk("stall_addr", l_cmd_addr, 24'h0ABCDE);
                    chk("stall_no_ready", m_cmd_ready, '0);
                end
                @(posedge clk);
                #1 l_cmd_ready = 1'b1;
            end
        join

        // Pointer now sits at port1, so a tie separates round-robin from fixed priority.
`ifdef LITEDRAM_ARB_FIXED_PRIO_EN
        expect_txn(0, 24'h000111, 1'b0, rdw(24'h000111), '0);
        expect_txn(1, 24'h000222, 1'b0, rdw(24'h000222), '0);
`else
        expect_txn(1, 24'h000222, 1'b0, rdw(24'h000222), '0);
        expect_txn(0, 24'h000111, 1'b0, rdw(24'h000111), '0);
`endif
        fork
            master(0, 24'h000111, 1'b0, '0, '0);
            master(1, 24'h000222, 1'b0, '0, '0);
        join

        expect_txn(1, 24'h000031, 1'b0, rdw(24'h000031), '0);
        expect_txn(0, 24'h000030, 1'b0, rdw(24'h000030), '0);
        expect_txn(1, 24'h000032, 1'b0, rdw(24'h000032), '0);
        expect_txn(1, 24'h000033, 1'b0, rdw(24'h000033), '0);
        fork
            begin
                master(1, 24'h000031, 1'b0, '0, '0);
                master(1, 24'h000032, 1'b0, '0, '0);
                master(1, 24'h000033, 1'b0, '0, '0);
            end
            begin step(); step(); master(0, 24'h000030, 1'b0, '0, '0); end
        join

        rd_hold = 1'b1;
        cq.push_back('{0, 24'h0000AA, 1'b0});
        m_cmd_valid[0] = 1'b1;
        m_cmd_addr[0 +: AW] = 24'h0000AA;
        m_cmd_we[0] = 1'b0;
        m_rdata_ready[0] = 1'b1;
        n = 0;
        while (!m_cmd_ready[0] && n < 64) begin step(); n++; end
        chk("rst_test_grant", m_cmd_ready, 2'b01);
        step();
        m_cmd_valid[0] = 1'b0;
        chk("rst_test_rready", l_rready, 1'b1);
        rd_force = 1'b1;
        #1;
        chk("rst_test_fwd", m_rdata_valid, 2'b01);
        rst_n = 1'b0;
        #1;
        chk("midrst_rdata_valid", m_rdata_valid, '0);
        chk("midrst_rready", l_rready, 1'b0);
        chk("midrst_cmd_valid", l_cmd_valid, 1'b0);
        chk("midrst_wvalid", l_wvalid, 1'b0);
        rd_force = 1'b0;
        rd_hold = 1'b0;
        m_rdata_ready[0] = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();

        expect_txn(1, 24'h000444, 1'b1, 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0CAFE, 16'h0FF0);
        master(1, 24'h000444, 1'b1, 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0CAFE, 16'h0FF0);
        expect_txn(0, 24'h000555, 1'b0, rdw(24'h000555), '0);
        master(0, 24'h000555, 1'b0, '0, '0);

        repeat (4) step();
        chk("cmd_queue_drained", cq.size(), 0);
        chk("wdata_queue_drained", wq.size(), 0);
        chk("rdata_queue_drained", rq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/litedram_port_arbiter.md
Name:
litedram_port_arbiter

Overview:
- Sits directly downstream of the LSU and of any other LiteDRAM native-port master, such as the instruction fetch unit.
- Merges NUM_PORTS master ports onto the single LiteDRAM native user port.
- Exactly one transaction is in flight at a time: command, then one write-data beat or one read-data beat.
- Round-robin arbitration between masters.

Parameters:
NUM_PORTS, 2, number of upstream master ports (2..4)
ADDR_W, 24, LiteDRAM command address width (128-bit word address)
DATA_W, 128, LiteDRAM data width; byte-enable width is DATA_W/8

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; one clock, asynchronous assertion, active-low
m_cmd_valid_i  in  NUM_PORTS  per-master command valid
m_cmd_ready_o  out  NUM_PORTS  per-master command ready
m_cmd_addr_i  in  NUM_PORTS*ADDR_W  per-master address, port k at slice k
m_cmd_we_i  in  NUM_PORTS  per-master write flag
m_wdata_valid_i  in  NUM_PORTS  per-master write-data valid
m_wdata_ready_o  out  NUM_PORTS  per-master write-data ready
m_wdata_data_i  in  NUM_PORTS*DATA_W  per-master write data
m_wdata_we_i  in  NUM_PORTS*DATA_W/8  per-master byte enables
m_rdata_valid_o  out  NUM_PORTS  per-master read-data valid
m_rdata_ready_i  in  NUM_PORTS  per-master read-data ready
m_rdata_data_o  out  DATA_W  read data, broadcast to all masters
litedram_cmd_valid_o  out  1  command valid
litedram_cmd_ready_i  in  1  command ready
litedram_cmd_addr_o  out  ADDR_W  command address
litedram_cmd_we_o  out  1  command write flag
litedram_wdata_valid_o  out  1  write-data valid
litedram_wdata_ready_i  in  1  write-data ready
litedram_wdata_data_o  out  DATA_W  write data
litedram_wdata_we_o  out  DATA_W/8  byte enables
litedram_rdata_valid_i  in  1  read-data valid
litedram_rdata_ready_o  out  1  read-data ready
litedram_rdata_data_i  in  DATA_W  read data

Behaviour:
- Registers: state, grant index, priority pointer. All other outputs are combinational functions of these and the inputs.
- Reset (rst_ni=0, asynchronous): state=IDLE, grant=0, pointer=0. With no handshake active, every valid/ready output is 0 and addr/we/data/byte-enable outputs are 0.
- IDLE:
  - If any m_cmd_valid_i is set, grant = first requester at or after the pointer, wrapping NUM_PORTS-1 -> 0; go to CMD next cycle.
  - All masters see ready=0 in IDLE.
- CMD:
  - litedram_cmd_valid_o/addr_o/we_o = the granted master's signals.
  - m_cmd_ready_o[grant] = litedram_cmd_ready_i; all other ready bits are 0.
  - On handshake: pointer = grant+1 (mod NUM_PORTS); go to WDATA if granted we=1, else RDATA.
  - Minimum latency: request in cycle t, litedram_cmd_valid_o at t+1.
- WDATA:
  - litedram_wdata_valid_o/data_o/we_o = granted master's signals.
  - m_wdata_ready_o[grant] = litedram_wdata_ready_i.
  - On handshake -> IDLE.
- RDATA:
  - m_rdata_valid_o[grant] = litedram_rdata_valid_i; litedram_rdata_ready_o = m_rdata_ready_i[grant].
  - m_rdata_data_o = litedram_rdata_data_i, unconditional broadcast.
  - On handshake -> IDLE.
- Non-granted masters always see valid/ready = 0. Their wdata and rdata_ready are ignored.
- Granted master drops m_cmd_valid_i in CMD before the handshake: undefined master behaviour. The arbiter stays in CMD with valid=0 until the handshake.
- Reset mid-transaction: immediate return to IDLE. The in-flight LiteDRAM beat is abandoned; the system resets both sides together.
- Back-to-back: IDLE always inserts one bubble cycle; full transaction is at least 3 cycles.

Optional Feature:
- LITEDRAM_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins; pointer register removed.
- Undefined: round-robin as above.

Decomposition:
- Package litedram_arb_pkg: state encodings ARB_IDLE=2'd0, ARB_CMD=2'd1, ARB_WDATA=2'd2, ARB_RDATA=2'd3, plus default widths.
- One sub-module rr_arbiter: combinational request vector + pointer -> grant index and any-valid flag. It also holds the fixed-priority variant.

Test Plan:
- Port0 read, addr 0x000123 -> litedram_cmd_addr_o=0x000123, we=0. rdata 0xDEADBEEF... -> m_rdata_valid_o=01 and data broadcast; returns to IDLE.
- Port1 write, data 0x...CAFE, we=16'h000F -> litedram wdata carries port1 data/we; m_wdata_ready_o=10 only.
- Both ports request in the same cycle after reset -> port0 served first, then port1. Repeat -> port0 then port1 again (alternation).
- litedram_cmd_ready_i held 0 for 5 cycles -> cmd_valid stays 1, addr stable, no master ready; proceeds on ready.
- Port1 requests continuously while port0 requests once -> port0 granted within one transaction. Repeat with LITEDRAM_ARB_FIXED_PRIO_EN: port0 always wins ties.
- rst_ni asserted during RDATA -> all valid outputs 0 immediately; next request after release is granted normally.
